// File: rtl/core_pkg.sv
// core_pkg: register-file constants shared by decode, writeback and the scoreboard.
package core_pkg;
    localparam int NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int SB_CNT_W = 2;
endpackage

// File: rtl/grf_sb_counter.sv
// grf_sb_counter: pending-write counter for one register with clear and underflow pulse.
module grf_sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         underflow
);
    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        underflow = dec && !inc && !clr && cnt == '0;
        nxt = clr ? '0 :
              (inc && !dec) ? cnt + ONE :
              (dec && !inc && cnt != '0) ? cnt - ONE : cnt;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= nxt;
endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: tracks in-flight register writes and stalls issue on RAW hazards
// or a saturated pending counter; same-cycle writebacks release stalls immediately.
module grf_scoreboard
    import core_pkg::*;
#(
    parameter int CNT_W   = SB_CNT_W,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rs,
    input  logic [4:0]         issue_rt,
    input  logic               use_rs,
    input  logic               use_rt,
    input  logic [4:0]         issue_dst,
    input  logic               issue_we,
    output logic               issue_ready,
    output logic               stall,
    input  logic               wb_valid,
    input  logic [4:0]         wb_dst,
    input  logic               flush,
    output logic               pending_any,
    output logic               underflow_err,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] eff [NUM_REGS];
    logic [NUM_REGS-1:1] uf, nz;
    logic rs_haz, rt_haz, full_haz;

    assign cnt[0] = '0;

    // eff is the count as seen after this cycle's writeback, so the regfile bypass can serve the read
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            eff[i] = (wb_valid && wb_dst == 5'(i) && i != 0 && cnt[i] != '0) ? cnt[i] - ONE : cnt[i];
        rs_haz = use_rs && issue_rs != REG_ZERO && eff[issue_rs] != '0;
        rt_haz = use_rt && issue_rt != REG_ZERO && eff[issue_rt] != '0;
        full_haz = issue_we && issue_dst != REG_ZERO && eff[issue_dst] == '1;
        issue_ready = issue_valid && !rs_haz && !rt_haz && !full_haz && !flush;
        stall = issue_valid && !issue_ready;
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        logic [CNT_W-1:0] nxt;
        grf_sb_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (issue_ready && issue_we && issue_dst == 5'(g)),
            .dec       (wb_valid && wb_dst == 5'(g)),
            .clr       (flush),
            .cnt       (cnt[g]),
            .nxt       (nxt),
            .underflow (uf[g])
        );
        assign nz[g] = |nxt;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pending_any   <= 1'b0;
            underflow_err <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            pending_any   <= |nz;
            underflow_err <= underflow_err | (|uf);
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Register-file scoreboard for the pipelined MIPS core. It sits beside the register file in the decode stage and tracks every in-flight register write between issue and writeback. It grants or stalls instruction issue so that no source is read before its producer has written it. A read in the same cycle as its writeback is allowed, because the register file forwards same-cycle writes to its read ports.

## Interface
Parameters:
- CNT_W, 2: width of each per-register pending counter. At most 2^CNT_W−1 writes may be outstanding per register.
- STALL_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode holds an instruction that wants to issue.
- issue_rs  in  5  first source register number (instr[25:21]).
- issue_rt  in  5  second source register number (instr[20:16]).
- use_rs  in  1  the instruction reads rs.
- use_rt  in  1  the instruction reads rt.
- issue_dst  in  5  destination register number.
- issue_we  in  1  the instruction writes issue_dst.
- issue_ready  out  1  issue accepted this cycle. Combinational.
- stall  out  1  equals issue_valid && !issue_ready.
- wb_valid  in  1  a writeback to the register file occurs this cycle.
- wb_dst  in  5  destination register of that writeback.
- flush  in  1  pipeline flush. Discards all pending state.
- pending_any  out  1  at least one counter is nonzero. Registered.
- underflow_err  out  1  sticky flag: a writeback arrived for a register with zero pending writes.
- stall_cnt  out  STALL_W  number of cycles in which stall was 1.

## Operation
- State: cnt[1..31], each CNT_W bits. cnt[0] does not exist and is treated as 0. Register $0 is never tracked, never stalls, and a writeback to it is ignored.
- wb_hit[r] = wb_valid && wb_dst==r && r!=0.
- eff[r] = cnt[r] − wb_hit[r], floored at 0.
- Hazard terms:
  - rs_haz = use_rs && issue_rs!=0 && eff[issue_rs]!=0
  - rt_haz = use_rt && issue_rt!=0 && eff[issue_rt]!=0
  - full_haz = issue_we && issue_dst!=0 && eff[issue_dst]==2^CNT_W−1
- issue_ready = issue_valid && !rs_haz && !rt_haz && !full_haz && !flush.
- Counter update for r≠0, with inc = issue_ready && issue_we && issue_dst==r:
  - inc and wb_hit: cnt unchanged.
  - inc only: cnt+1. Overflow is impossible because of full_haz.
  - wb_hit only: cnt−1. If cnt==0, cnt stays 0 and underflow_err is set.
- flush: all counters clear to 0 next edge, and no issue is accepted that cycle. A wb_hit in the same cycle is consumed silently. Writebacks in later cycles for cleared registers take the underflow path; the flushing logic must drain them first, otherwise underflow_err records the violation.
- underflow_err clears only on reset.
- stall_cnt increments when stall==1 and saturates at all-ones.
- WAW ordering is preserved by counting. RAW is resolved by the stall. WAR cannot occur in the in-order pipeline.

## Timing
- Reset (reset=0, asynchronous): all cnt=0, pending_any=0, underflow_err=0, stall_cnt=0. issue_ready then depends only on issue_valid and flush.
- issue_ready and stall are combinational from the inputs and current state, with zero latency.
- Counters, pending_any, underflow_err and stall_cnt update on the rising clk edge after the event and are visible one cycle later.
- A writeback in cycle N to a stalled source releases the stall in cycle N itself, through eff.
- Reset asserted mid-operation discards all pending counts immediately. Releasing reset produces no spurious outputs.

## Structure
- Shared package core_pkg holds NUM_REGS=32, REG_ZERO=5'd0, and the default SB_CNT_W=2. The decode and writeback stages use the same constants.
- One sub-module, grf_sb_counter: a single saturating up/down counter with inc, dec, clr and an underflow pulse. It is instantiated 31 times. The top level holds the hazard logic, OR-reduces underflow, and contains the performance counter.

## Test plan
- Issue writes $8, then next cycle issue reads rs=$8 with no writeback → stall=1 and stall_cnt increments each cycle. Writeback of $8 in cycle N → issue_ready=1 in cycle N, and cnt[8] returns to 0.
- Issue writes to $0 and reads of $0 → never stall, pending_any stays 0. wb_dst=0 leaves underflow_err=0.
- Three issues writing $5 with no writeback → cnt[5]=3. A fourth issue writing $5 → full_haz stall. A wb of $5 in the same cycle → accepted, cnt stays 3.
- Same cycle: an issue writing $9 and a wb of $9 with cnt[9]=1 → cnt[9] stays 1 and pending_any=1.
- Two outstanding writes, then flush → no issue accepted that cycle, all counters 0 and pending_any=0 next cycle. A later wb of $7 → underflow_err=1, sticky.
- Assert reset asynchronously between edges with cnt[3]=2 and stall_cnt=10 → outputs are 0 immediately. After reset release, a read of $3 issues without stall.
